// File: rtl/sixbitsub_if.sv
// Operand/result bundle for the 6-bit registered subtractor.
// The master drives the operands and the slave returns the registered result.
interface sixbitsub_if;
  logic [5:0] ain;
  logic [5:0] bin;
  logic [5:0] diff;
  logic       overflow;

  modport master (output ain, output bin, input diff, input overflow);
  modport slave  (input ain, input bin, output diff, output overflow);
endinterface

// File: rtl/sixbitsub.sv
// 6-bit two's-complement subtractor: ain + ~bin + 1 through a ripple chain of
// full-adder cells, with the difference and signed overflow registered.
module sixbitsub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sixbitsub (
  input  logic       clk,
  input  logic       rst,
  sixbitsub_if.slave io
);
  localparam int W = 6;

  logic [W-1:0] bin_n;
  logic [W-1:0] sum;
  logic [W:0]   c;
  logic [W-1:0] diff_d, diff_q;
  logic         overflow_d, overflow_q;

  // Carry-in of 1 completes the two's-complement negation of bin.
  assign bin_n = ~io.bin;
  assign c[0]  = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    sixbitsub_fa u_fa (
      .a  (io.ain[i]),
      .b  (bin_n[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  always_comb begin
    diff_d     = sum;
    overflow_d = c[W-1] ^ c[W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      diff_q     <= diff_d;
      overflow_q <= overflow_d;
    end
  end

  assign io.diff     = diff_q;
  assign io.overflow = overflow_q;
endmodule

// File: tb/tb_sixbitsub.sv
// Scoreboard bench for sixbitsub: expectations are queued as operands are
// driven and retired one edge later against the registered outputs.
module tb_sixbitsub;
  typedef struct packed {
    logic [5:0] d;
    logic       o;
  } exp_t;

  logic clk;
  logic rst;
  sixbitsub_if sb_if ();

  sixbitsub dut (
    .clk (clk),
    .rst (rst),
    .io  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_chk;
  int   n_fail;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] a, input logic [5:0] b);
    exp_t e;
    int   da, db, r;
    da  = a[5] ? int'(a) - 64 : int'(a);
    db  = b[5] ? int'(b) - 64 : int'(b);
    r   = da - db;
    e.d = 6'(r & 63);
    e.o = (r > 31) || (r < -32);
    return e;
  endfunction

  task automatic step(input logic r, input logic [5:0] a, input logic [5:0] b, input string tag);
    exp_t e;
    @(negedge clk);
    rst       = r;
    sb_if.ain = a;
    sb_if.bin = b;
    if (r) e = '0;
    else   e = model(a, b);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("%s.diff", tag), {2'b00, sb_if.diff}, {2'b00, e.d});
    chk($sformatf("%s.ovf", tag), {7'b0, sb_if.overflow}, {7'b0, e.o});
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    sb_if.ain = '0;
    sb_if.bin = '0;

    step(1'b1, 6'd5, 6'd3, "rst0");
    step(1'b1, 6'd5, 6'd3, "rst1");
    step(1'b0, 6'd5, 6'd3, "release");

    step(1'b0, 6'b011111, 6'b111111, "pos_ovf");
    step(1'b0, 6'b100000, 6'b000001, "neg_ovf");
    step(1'b0, 6'b000000, 6'b000001, "uwrap");
    step(1'b0, 6'b000000, 6'b100000, "zero_m32");
    step(1'b0, 6'd9, 6'd9, "equal");
    step(1'b0, 6'd45, 6'd0, "bin_zero");
    for (int k = 0; k < 5; k++) step(1'b0, 6'd7, 6'd2, "hold");

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        if (a == 20 && b == 5) step(1'b1, 6'(a), 6'(b), "midrst");
        step(1'b0, 6'(a), 6'(b), $sformatf("sw_%0d_%0d", a, b));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
